// File: rtl/hier_node_pkg.sv
// Shared types and helpers for the hierarchical dispatch node.
package hier_node_pkg;

  // Node controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    WAIT   = 2'd2,
    REPORT = 2'd3
  } state_e;

  // Dispatch mode encoding carried on up_req_seq
  localparam logic MODE_PAR = 1'b0;
  localparam logic MODE_SEQ = 1'b1;

  // Largest supported child count; onehot() returns a vector this wide
  localparam int MAX_CHILDREN = 32;

  // One-hot vector with bit idx set, or all zeros when idx is out of range
  function automatic logic [MAX_CHILDREN-1:0] onehot(input int unsigned idx,
                                                     input int unsigned n);
    logic [MAX_CHILDREN-1:0] r;
    r = '0;
    if (idx < n && idx < MAX_CHILDREN) begin
      r = {{(MAX_CHILDREN-1){1'b0}}, 1'b1} << idx;
    end
    return r;
  endfunction

endpackage

// File: rtl/hier_dispatch_node_timeout.sv
// Saturating wait-phase counter with compare-to-limit; a zero limit disables expiry.
module hier_node_timeout #(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [TO_W-1:0] limit,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;
  logic [TO_W-1:0] cnt_inc;

  // Next count: clear wins, otherwise count up and stick at all ones
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_inc;
    end
    // Expiry looks at the value this cycle brings the count to, so a limit
    // of L fires on the L-th counted cycle.
    expired = en && !clr && (limit != '0) && (cnt_inc >= limit);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hier_dispatch_node.sv
// Generic tree node: takes one job from its parent, fans it out to the
// children in parallel or one at a time, gathers done/error/timeout status
// and hands a single aggregated completion back up.
//
// Handshakes: a transfer on up_req or up_done happens on a rising clk edge
// where valid and ready are both high; the node never drops up_done_valid or
// changes its payload until that transfer occurs.
module hier_dispatch_node
  import hier_node_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int ID_W         = 8,
  parameter int TO_W         = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_req_valid,
  output logic                    up_req_ready,
  input  logic [ID_W-1:0]         up_req_id,
  input  logic                    up_req_seq,
  input  logic [TO_W-1:0]         timeout_limit,
  output logic [NUM_CHILDREN-1:0] child_start,
  output logic [ID_W-1:0]         child_id,
  input  logic [NUM_CHILDREN-1:0] child_done,
  input  logic [NUM_CHILDREN-1:0] child_err,
  output logic                    up_done_valid,
  input  logic                    up_done_ready,
  output logic [ID_W-1:0]         up_done_id,
  output logic [NUM_CHILDREN-1:0] up_err_mask,
  output logic [NUM_CHILDREN-1:0] up_to_mask,
  output logic                    busy
);

  localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;
  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_CHILDREN - 1);
  localparam logic [NUM_CHILDREN-1:0] ALL_ONES = '1;

  state_e                  state_q, state_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic                    seq_q, seq_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHILDREN-1:0] pending_q, pending_d;
  logic [NUM_CHILDREN-1:0] err_mask_q, err_mask_d;
  logic [NUM_CHILDREN-1:0] to_mask_q, to_mask_d;

  logic                    to_clr;
  logic                    to_en;
  logic                    to_expired;
  logic [MAX_CHILDREN-1:0] seq_onehot;
  logic [NUM_CHILDREN-1:0] start_mask;
  logic [NUM_CHILDREN-1:0] pend_next;
  logic                    phase_end;

  // Wait-phase timeout counter, restarted on every START
  hier_node_timeout #(
    .TO_W (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (to_clr),
    .en      (to_en),
    .limit   (timeout_limit),
    .expired (to_expired)
  );

  // Children targeted by the current START: everyone, or just child idx
  always_comb begin
    seq_onehot = onehot(32'(idx_q), NUM_CHILDREN);
    start_mask = (seq_q == MODE_SEQ) ? seq_onehot[NUM_CHILDREN-1:0] : ALL_ONES;
  end

  // Next-state and output logic of the dispatch FSM
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    seq_d         = seq_q;
    idx_d         = idx_q;
    pending_d     = pending_q;
    err_mask_d    = err_mask_q;
    to_mask_d     = to_mask_q;
    to_clr        = 1'b0;
    to_en         = 1'b0;
    pend_next     = pending_q;
    phase_end     = 1'b0;
    up_req_ready  = 1'b0;
    up_done_valid = 1'b0;
    child_start   = '0;

    case (state_q)
      IDLE: begin
        up_req_ready = 1'b1;
        if (up_req_valid) begin
          id_d    = up_req_id;
          seq_d   = up_req_seq;
          idx_d   = '0;
          state_d = START;
        end
      end

      START: begin
        child_start = start_mask;
        pending_d   = start_mask;
        to_clr      = 1'b1;
        state_d     = WAIT;
      end

      WAIT: begin
        to_en      = 1'b1;
        pend_next  = pending_q & ~child_done;
        // Only a done from a child we are still waiting on may flag an error
        err_mask_d = err_mask_q | (child_err & child_done & pending_q);
        if (pend_next == '0) begin
          phase_end = 1'b1;
        end else if (to_expired) begin
          // Children that answered this very cycle are already out of pend_next
          to_mask_d = to_mask_q | pend_next;
          pend_next = '0;
          phase_end = 1'b1;
        end
        pending_d = pend_next;
        if (phase_end) begin
          if (seq_q == MODE_PAR || idx_q == LAST_IDX) begin
            state_d = REPORT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = START;
          end
        end
      end

      REPORT: begin
        up_done_valid = 1'b1;
        if (up_done_ready) begin
          err_mask_d = '0;
          to_mask_d  = '0;
          pending_d  = '0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= '0;
      seq_q      <= MODE_PAR;
      idx_q      <= '0;
      pending_q  <= '0;
      err_mask_q <= '0;
      to_mask_q  <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      seq_q      <= seq_d;
      idx_q      <= idx_d;
      pending_q  <= pending_d;
      err_mask_q <= err_mask_d;
      to_mask_q  <= to_mask_d;
    end
  end

  // Registered-state outputs; completion payload only shown while reporting
  always_comb begin
    busy        = (state_q != IDLE);
    child_id    = id_q;
    up_done_id  = (state_q == REPORT) ? id_q : '0;
    up_err_mask = (state_q == REPORT) ? err_mask_q : '0;
    up_to_mask  = (state_q == REPORT) ? to_mask_q : '0;
  end

endmodule

// File: tb/tb_hier_dispatch_node.sv
// Directed bench for hier_dispatch_node with a completion scoreboard.
module tb_hier_dispatch_node;

  localparam int N     = 5;
  localparam int ID_W  = 8;
  localparam int TO_W  = 16;
  localparam int EXP_W = ID_W + 2 * N;

  logic            clk;
  logic            rst_n;
  logic            up_req_valid;
  logic            up_req_ready;
  logic [ID_W-1:0] up_req_id;
  logic            up_req_seq;
  logic [TO_W-1:0] timeout_limit;
  logic [N-1:0]    child_start;
  logic [ID_W-1:0] child_id;
  logic [N-1:0]    child_done;
  logic [N-1:0]    child_err;
  logic            up_done_valid;
  logic            up_done_ready;
  logic [ID_W-1:0] up_done_id;
  logic [N-1:0]    up_err_mask;
  logic [N-1:0]    up_to_mask;
  logic            busy;

  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  hier_dispatch_node #(
    .NUM_CHILDREN (N),
    .ID_W         (ID_W),
    .TO_W         (TO_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .up_req_valid  (up_req_valid),
    .up_req_ready  (up_req_ready),
    .up_req_id     (up_req_id),
    .up_req_seq    (up_req_seq),
    .timeout_limit (timeout_limit),
    .child_start   (child_start),
    .child_id      (child_id),
    .child_done    (child_done),
    .child_err     (child_err),
    .up_done_valid (up_done_valid),
    .up_done_ready (up_done_ready),
    .up_done_id    (up_done_id),
    .up_err_mask   (up_err_mask),
    .up_to_mask    (up_to_mask),
    .busy          (busy)
  );

  // Advance one clock and settle past the edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [ID_W-1:0] id, input logic [N-1:0] err,
                          input logic [N-1:0] to);
    exp_q.push_back({id, err, to});
  endtask

  // Compare the completion currently presented against the oldest expectation
  task automatic check_done(input string tag);
    logic [EXP_W-1:0] e;
    chk({tag, "_valid"}, 32'(up_done_valid), 32'd1);
    n_checks++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_id"},  32'(up_done_id),  32'(e[EXP_W-1 -: ID_W]));
      chk({tag, "_err"}, 32'(up_err_mask), 32'(e[2*N-1 -: N]));
      chk({tag, "_to"},  32'(up_to_mask),  32'(e[N-1:0]));
    end
  endtask

  // Present a job for one accepting edge; ends in START
  task automatic issue(input logic [ID_W-1:0] id, input logic seq);
    up_req_id    = id;
    up_req_seq   = seq;
    up_req_valid = 1'b1;
    chk("issue_ready", 32'(up_req_ready), 32'd1);
    cycle();
    up_req_valid = 1'b0;
    chk("issue_busy", 32'(busy), 32'd1);
  endtask

  // Drive child responses for exactly one cycle
  task automatic pulse(input logic [N-1:0] done, input logic [N-1:0] err);
    child_done = done;
    child_err  = err;
    cycle();
    child_done = '0;
    child_err  = '0;
  endtask

  task automatic handshake(input string tag);
    up_done_ready = 1'b1;
    cycle();
    up_done_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(up_done_valid), 32'd0);
    chk({tag, "_hs_busy"},  32'(busy),          32'd0);
    chk({tag, "_hs_ready"}, 32'(up_req_ready),  32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    up_req_valid  = 1'b0;
    up_req_id     = '0;
    up_req_seq    = 1'b0;
    timeout_limit = '0;
    child_done    = '0;
    child_err     = '0;
    up_done_ready = 1'b0;
    repeat (3) cycle();

    // Reset state
    chk("rst_ready", 32'(up_req_ready),  32'd1);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_start", 32'(child_start),   32'd0);
    chk("rst_valid", 32'(up_done_valid), 32'd0);
    chk("rst_cid",   32'(child_id),      32'd0);
    rst_n = 1'b1;
    cycle();

    // Parallel job, all children answer two cycles after start
    push_exp(8'h5A, 5'b00000, 5'b00000);
    issue(8'h5A, 1'b0);
    chk("par_start", 32'(child_start), 32'h1F);
    chk("par_cid",   32'(child_id),    32'h5A);
    cycle();
    chk("par_start_pulse", 32'(child_start),   32'd0);
    chk("par_wait_valid",  32'(up_done_valid), 32'd0);
    cycle();
    pulse(5'b11111, 5'b00000);
    check_done("par");
    handshake("par");

    // Sequential job, child 2 reports an error
    push_exp(8'hA1, 5'b00100, 5'b00000);
    issue(8'hA1, 1'b1);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("seq_start%0d", i), 32'(child_start), 32'(1) << i);
      cycle();
      pulse(5'(1 << i), (i == 2) ? 5'(1 << i) : 5'b00000);
    end
    check_done("seq");
    handshake("seq");

    // Spurious done from a non-pending child is ignored
    push_exp(8'hB2, 5'b00000, 5'b00000);
    issue(8'hB2, 1'b1);
    chk("spur_start0", 32'(child_start), 32'h01);
    cycle();
    pulse(5'b10000, 5'b10000);
    chk("spur_hold_start", 32'(child_start),   32'd0);
    chk("spur_hold_valid", 32'(up_done_valid), 32'd0);
    chk("spur_hold_busy",  32'(busy),          32'd1);
    pulse(5'b00001, 5'b00000);
    for (int i = 1; i < N; i++) begin
      chk($sformatf("spur_start%0d", i), 32'(child_start), 32'(1) << i);
      cycle();
      pulse(5'(1 << i), 5'b00000);
    end
    check_done("spur");
    handshake("spur");

    // Timeout: child 3 never answers, limit 10
    timeout_limit = 16'd10;
    push_exp(8'hC3, 5'b00000, 5'b01000);
    issue(8'hC3, 1'b0);
    chk("to_start", 32'(child_start), 32'h1F);
    cycle();
    pulse(5'b10111, 5'b00000);
    for (int k = 2; k < 10; k++) begin
      chk($sformatf("to_wait%0d", k), 32'(up_done_valid), 32'd0);
      cycle();
    end
    chk("to_wait10", 32'(up_done_valid), 32'd0);
    cycle();
    chk("to_fire", 32'(up_done_valid), 32'd1);
    pulse(5'b01000, 5'b01000);
    check_done("to");
    handshake("to");

    // Done arriving on the timeout cycle wins
    timeout_limit = 16'd3;
    push_exp(8'hD4, 5'b00000, 5'b00000);
    issue(8'hD4, 1'b0);
    cycle();
    pulse(5'b10111, 5'b00000);
    cycle();
    pulse(5'b01000, 5'b00000);
    check_done("race");
    handshake("race");
    timeout_limit = '0;

    // Back-pressure on completion with a new request waiting
    push_exp(8'h33, 5'b00000, 5'b00000);
    issue(8'h33, 1'b0);
    cycle();
    pulse(5'b11111, 5'b00000);
    chk("bp_latency", 32'(up_done_valid), 32'd1);
    up_req_id    = 8'h44;
    up_req_seq   = 1'b0;
    up_req_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      chk("bp_valid", 32'(up_done_valid), 32'd1);
      chk("bp_id",    32'(up_done_id),    32'h33);
      chk("bp_err",   32'(up_err_mask),   32'd0);
      chk("bp_to",    32'(up_to_mask),    32'd0);
      chk("bp_ready", 32'(up_req_ready),  32'd0);
      cycle();
    end
    check_done("bp");
    up_done_ready = 1'b1;
    cycle();
    up_done_ready = 1'b0;
    chk("bp_no_accept_busy",  32'(busy),         32'd0);
    chk("bp_no_accept_ready", 32'(up_req_ready), 32'd1);
    push_exp(8'h44, 5'b00000, 5'b00000);
    cycle();
    up_req_valid = 1'b0;
    chk("bp_accept_busy",  32'(busy),        32'd1);
    chk("bp_accept_start", 32'(child_start), 32'h1F);
    chk("bp_accept_cid",   32'(child_id),    32'h44);
    cycle();
    pulse(5'b11111, 5'b00000);
    check_done("bp2");
    handshake("bp2");

    // Reset in the middle of WAIT abandons the job
    issue(8'h77, 1'b0);
    cycle();
    pulse(5'b00010, 5'b00010);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_busy",  32'(busy),          32'd0);
    chk("mid_rst_ready", 32'(up_req_ready),  32'd1);
    chk("mid_rst_start", 32'(child_start),   32'd0);
    chk("mid_rst_valid", 32'(up_done_valid), 32'd0);
    chk("mid_rst_id",    32'(up_done_id),    32'd0);
    chk("mid_rst_err",   32'(up_err_mask),   32'd0);
    chk("mid_rst_to",    32'(up_to_mask),    32'd0);
    chk("mid_rst_cid",   32'(child_id),      32'd0);
    rst_n = 1'b1;
    cycle();
    chk("post_rst_valid", 32'(up_done_valid), 32'd0);
    push_exp(8'h88, 5'b00000, 5'b00000);
    issue(8'h88, 1'b0);
    cycle();
    pulse(5'b11111, 5'b00000);
    check_done("post_rst");
    handshake("post_rst");

    // Every expected completion must have been consumed
    n_checks++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hier_dispatch_node.md
Name: hier_dispatch_node

Overview:
Parametrised hierarchy node that replaces fixed five-child structural nodes with one generic, handshaked node.
- Accepts one job from its parent and dispatches it to NUM_CHILDREN child instances, either in parallel or one child at a time.
- Collects per-child done/error responses, enforces a programmable timeout and returns one aggregated completion upstream.
- Instances chain recursively to form arbitrary-depth trees.

Parameters:
NUM_CHILDREN, 5, number of child ports (1..32)
ID_W, 8, job identifier width
TO_W, 16, timeout counter width
IDX_W, $clog2(NUM_CHILDREN) (min 1), child index width (derived localparam)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
up_req_valid  in  1  parent job request
up_req_ready  out  1  node can accept a job
up_req_id  in  ID_W  job id
up_req_seq  in  1  0 = parallel dispatch, 1 = sequential dispatch
timeout_limit  in  TO_W  cycles allowed per wait phase; 0 disables timeout
child_start  out  NUM_CHILDREN  one-cycle start pulse per child
child_id  out  ID_W  job id broadcast to children
child_done  in  NUM_CHILDREN  one-cycle completion pulse per child
child_err  in  NUM_CHILDREN  error flag, sampled with child_done
up_done_valid  out  1  completion to parent
up_done_ready  in  1  parent accepts completion
up_done_id  out  ID_W  id of the completed job
up_err_mask  out  NUM_CHILDREN  children that reported an error
up_to_mask  out  NUM_CHILDREN  children that timed out
busy  out  1  high in any state other than IDLE

Behaviour:
Reset (rst_n low at a clk edge):
- State goes to IDLE.
- All outputs go to 0, except up_req_ready, which is 1.
- Masks, counters and the stored id are cleared.
- Reset mid-job abandons the job; no up_done is issued.

States: IDLE, START, WAIT, REPORT.

IDLE:
- up_req_ready = 1.
- On up_req_valid & up_req_ready: latch id and seq, set idx = 0, go to START.
- Accept latency is 1 cycle.

START (one cycle):
- Parallel: child_start = all ones; pending = all ones.
- Sequential: child_start = onehot(idx); pending = onehot(idx).
- Timeout counter cleared. Go to WAIT.

WAIT:
- child_id holds the latched id from START until REPORT exits.
- Each cycle: pending &= ~child_done.
- child_err bits are ORed into err_mask only where child_done & pending. A done from a non-pending child is ignored.
- Timeout counter increments each WAIT cycle and saturates at all ones.
- Completion of the phase, when pending becomes 0 (using the next-value of pending):
  - Parallel: go to REPORT.
  - Sequential, idx < NUM_CHILDREN-1: idx++, go to START.
  - Sequential, last child: go to REPORT.
- Timeout, when timeout_limit != 0 and the counter reaches timeout_limit with pending still nonzero:
  - to_mask |= pending, pending = 0.
  - Sequential mode then continues with the next child exactly as on normal completion.
- If a done arrives in the same cycle the timeout fires, the done wins and that bit is not marked in to_mask.

REPORT:
- up_done_valid = 1; up_done_id, up_err_mask and up_to_mask are stable while valid is high.
- On up_done_ready: clear all masks, go to IDLE. up_req_ready returns to 1 on the following cycle (no accept in the same cycle).
- up_done_valid must not drop without ready.

Latency:
- Parallel job where all children answer on their first WAIT cycle: accept → done_valid = 3 cycles.
- Sequential mode adds 2 cycles per child.

Masks and ids are not arithmetically combined; idx compare uses IDX_W bits.

Decomposition:
- Shared package hier_node_pkg holds:
  - the state enum typedef (IDLE/START/WAIT/REPORT);
  - localparams for the mode encoding (MODE_PAR = 0, MODE_SEQ = 1);
  - a helper function onehot(idx, n).
- One natural sub-module: hier_node_timeout (loadable saturating counter with compare-to-limit and disable-on-zero), instantiated once.
- Child instances themselves stay outside this block.

Test Plan:
- Parallel, id 0x5A, NUM_CHILDREN = 5, all child_done asserted 2 cycles after start → child_start = 5'b11111 for 1 cycle; up_done_valid with id 0x5A, err 0, to 0; busy drops after the ready handshake.
- Sequential, children answer after 1 cycle each, child 2 with err → child_start pulses 00001, 00010, 00100, 01000, 10000 in order; err_mask = 5'b00100.
- timeout_limit = 10, child 3 never answers, parallel → after 10 WAIT cycles up_done_valid with to_mask = 5'b01000; a late child_done[3] is ignored.
- Spurious child_done[4] while only child 0 is pending (sequential) → no state change and no mask bit set; sequencing continues normally.
- Back-pressure: hold up_done_ready = 0 for 20 cycles → outputs stable and up_req_ready = 0; a new up_req_valid is not accepted until 1 cycle after the handshake.
- rst_n low during WAIT → next cycle: IDLE, all outputs 0, up_req_ready = 1; a later job completes normally with clean masks.
